// File: rtl/uart_rx_gen2.sv
// Oversampling UART receiver: 2-flop input synchronizer, majority-vote bit sampling,
// optional parity, one or two stop bits, break detection and a small receive FIFO.
module uart_rx_gen2 #(
    parameter int DATA_BITS  = 8,
    parameter int OSR        = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rx_en,
    input  logic                 rxd,
    input  logic [2:0]           parity_mode,
    input  logic                 stop2,
    input  logic                 rx_ready,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_valid,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    localparam int CW   = $clog2(OSR);
    localparam int BW   = $clog2(DATA_BITS + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int NW   = AW + 1;
    localparam int WW   = DATA_BITS + 2;

    localparam logic [CW-1:0] CNT_S0   = CW'(OSR / 2 - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(OSR / 2);
    localparam logic [CW-1:0] CNT_VOTE = CW'(OSR / 2 + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [NW-1:0] CNT_FULL = NW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    // Input synchronizer
    logic rxd_meta_q;
    logic rxd_sync_q;

    // Frame FSM
    state_t                 state_q,      state_d;
    logic [CW-1:0]          sample_cnt_q, sample_cnt_d;
    logic [BW-1:0]          bit_cnt_q,    bit_cnt_d;
    logic [DATA_BITS-1:0]   shift_q,      shift_d;
    logic                   samp_a_q,     samp_a_d;
    logic                   samp_b_q,     samp_b_d;
    logic                   perr_q,       perr_d;
    logic                   ferr_q,       ferr_d;
    logic                   par_bit_q,    par_bit_d;
    logic                   break_det_q;

    logic                   vote;
    logic                   par_en;
    logic                   par_exp;
    logic                   stop_ferr;
    logic                   in_frame;
    logic                   push;
    logic                   break_fire;
    logic [WW-1:0]          push_word;

    // Receive FIFO
    logic [WW-1:0]          mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [NW-1:0]          count_q, count_d;
    logic                   overrun_q;
    logic                   pop;
    logic                   full;
    logic                   push_ok;
    logic                   ovr_set;
    logic [WW-1:0]          head;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
        end
    end

    // Two earlier samples are latched; the third is the live synchronized value at the vote point.
    assign vote = (samp_a_q & samp_b_q) | (samp_a_q & rxd_sync_q) | (samp_b_q & rxd_sync_q);

    assign par_en = (parity_mode >= 3'd1) && (parity_mode <= 3'd4);

    always_comb begin
        case (parity_mode)
            3'd1:    par_exp = ^shift_q;
            3'd2:    par_exp = ~(^shift_q);
            3'd3:    par_exp = 1'b1;
            default: par_exp = 1'b0;
        endcase
    end

    assign stop_ferr = ferr_q | ~vote;
    assign push_word = {perr_q, stop_ferr, shift_q};
    assign in_frame  = (state_q == S_START) || (state_q == S_DATA) ||
                       (state_q == S_PARITY) || (state_q == S_STOP);

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        samp_a_d     = samp_a_q;
        samp_b_d     = samp_b_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        par_bit_d    = par_bit_q;
        push         = 1'b0;
        break_fire   = 1'b0;

        if (!rx_en) begin
            state_d      = S_IDLE;
            sample_cnt_d = '0;
            bit_cnt_d    = '0;
        end else if (sample_tick) begin
            if (in_frame) begin
                sample_cnt_d = (sample_cnt_q == CNT_LAST) ? '0 : sample_cnt_q + CW'(1);
                if (sample_cnt_q == CNT_S0) samp_a_d = rxd_sync_q;
                if (sample_cnt_q == CNT_S1) samp_b_d = rxd_sync_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (!rxd_sync_q) begin
                        state_d      = S_START;
                        sample_cnt_d = '0;
                        bit_cnt_d    = '0;
                        perr_d       = 1'b0;
                        ferr_d       = 1'b0;
                        par_bit_d    = 1'b0;
                    end
                end
                S_START: begin
                    if (sample_cnt_q == CNT_VOTE && vote) begin
                        state_d      = S_IDLE;
                        sample_cnt_d = '0;
                    end else if (sample_cnt_q == CNT_LAST) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    if (sample_cnt_q == CNT_VOTE) begin
                        shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    end
                    if (sample_cnt_q == CNT_LAST) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d   = par_en ? S_PARITY : S_STOP;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (sample_cnt_q == CNT_VOTE) begin
                        par_bit_d = vote;
                        perr_d    = (vote != par_exp);
                    end
                    if (sample_cnt_q == CNT_LAST) begin
                        state_d   = S_STOP;
                        bit_cnt_d = '0;
                    end
                end
                S_STOP: begin
                    if (sample_cnt_q == CNT_VOTE) begin
                        ferr_d = stop_ferr;
                        // Final stop bit finishes the frame mid-bit so the next start edge is never missed.
                        if (!stop2 || bit_cnt_q == BW'(1)) begin
                            sample_cnt_d = '0;
                            bit_cnt_d    = '0;
                            if (stop_ferr && shift_q == '0 && (!par_en || !par_bit_q)) begin
                                break_fire = 1'b1;
                                state_d    = S_BREAK;
                            end else begin
                                push    = 1'b1;
                                state_d = S_IDLE;
                            end
                        end
                    end else if (sample_cnt_q == CNT_LAST) begin
                        bit_cnt_d = BW'(1);
                    end
                end
                S_BREAK: begin
                    if (rxd_sync_q) state_d = S_IDLE;
                end
                default: begin
                    state_d      = S_IDLE;
                    sample_cnt_d = '0;
                    bit_cnt_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sample_cnt_q <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            samp_a_q     <= 1'b1;
            samp_b_q     <= 1'b1;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            par_bit_q    <= 1'b0;
            break_det_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            samp_a_q     <= samp_a_d;
            samp_b_q     <= samp_b_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            par_bit_q    <= par_bit_d;
            break_det_q  <= break_fire;
        end
    end

    // Output handshake: a word transfers on any rising edge where rx_valid and rx_ready are both 1;
    // rx_valid never drops without a transfer, and the head fields are stable while rx_valid is 1.
    assign pop     = rx_valid && rx_ready;
    assign full    = (count_q == CNT_FULL);
    assign push_ok = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_word;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            if (ovr_set) overrun_q <= 1'b1;
            else if (err_clr) overrun_q <= 1'b0;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign rx_data   = head[DATA_BITS-1:0];
    assign rx_ferr   = head[DATA_BITS];
    assign rx_perr   = head[DATA_BITS+1];
    assign rx_valid  = (count_q != '0);
    assign overrun   = overrun_q;
    assign break_det = break_det_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_gen2.sv
// Self-checking bench for uart_rx_gen2: serial frames are driven bit by bit, expected words
// are queued when a frame is sent and compared as the FIFO head is popped.
module tb_uart_rx_gen2;

    localparam int DATA_BITS  = 8;
    localparam int OSR        = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int TICK_DIV   = 4;
    localparam int BIT_CLKS   = OSR * TICK_DIV;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 sample_tick;
    logic                 rx_en;
    logic                 rxd;
    logic [2:0]           parity_mode;
    logic                 stop2;
    logic                 rx_ready;
    logic                 err_clr;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_perr;
    logic                 rx_ferr;
    logic                 rx_valid;
    logic                 overrun;
    logic                 break_det;
    logic                 busy;
    logic [2:0]           dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int brk_cnt  = 0;
    logic [DATA_BITS+1:0] exp_q[$];

    // Clock and reset
    always #5 clk = ~clk;

    uart_rx_gen2 #(
        .DATA_BITS (DATA_BITS),
        .OSR       (OSR),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_tick(sample_tick),
        .rx_en      (rx_en),
        .rxd        (rxd),
        .parity_mode(parity_mode),
        .stop2      (stop2),
        .rx_ready   (rx_ready),
        .err_clr    (err_clr),
        .rx_data    (rx_data),
        .rx_perr    (rx_perr),
        .rx_ferr    (rx_ferr),
        .rx_valid   (rx_valid),
        .overrun    (overrun),
        .break_det  (break_det),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    initial begin
        sample_tick = 1'b0;
        forever begin
            for (int k = 0; k < TICK_DIV; k++) begin
                @(negedge clk);
                sample_tick = (k == 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    function automatic logic par_on(input logic [2:0] m);
        return (m >= 3'd1) && (m <= 3'd4);
    endfunction

    function automatic logic par_of(input logic [7:0] d, input logic [2:0] m);
        case (m)
            3'd1:    return ^d;
            3'd2:    return ~(^d);
            3'd3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        rx_ready = v;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [2:0] m, input logic bad_par,
                              input logic stop_v, input logic expect_it);
        logic                 pb;
        logic [DATA_BITS+1:0] w;
        parity_mode = m;
        pb = par_of(d, m) ^ bad_par;
        w  = {par_on(m) & bad_par, ~stop_v, d};
        if (expect_it) exp_q.push_back(w);
        drive_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) drive_bit(d[i]);
        if (par_on(m)) drive_bit(pb);
        if (stop2) drive_bit(1'b1);
        drive_bit(stop_v);
    endtask

    task automatic watch_push();
        int   t = 0;
        logic seen_busy = 1'b0;
        logic prev_valid = 1'b0;
        logic done = 1'b0;
        while (!done && t < 2000) begin
            @(negedge clk);
            t++;
            if (busy) begin
                seen_busy = 1'b1;
            end else if (seen_busy) begin
                check("valid_after_stop_vote", rx_valid, 1'b1);
                check("valid_low_before_push", prev_valid, 1'b0);
                done = 1'b1;
            end
            prev_valid = rx_valid;
        end
        if (!done) check("push_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("sb_drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", {rx_perr, rx_ferr, rx_data}, 32'h3ff_0000);
            end else begin
                check("rx_word", {rx_perr, rx_ferr, rx_data}, exp_q.pop_front());
            end
        end
        if (break_det) brk_cnt++;
    end

    initial begin
        logic [2:0] modes [6];
        logic [7:0] d;
        modes = '{3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1};

        rst = 1'b1; rx_en = 1'b1; rxd = 1'b1; parity_mode = 3'd0;
        stop2 = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_data", rx_data, 8'h00);
        check("rst_perr", rx_perr, 1'b0);
        check("rst_ferr", rx_ferr, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_break", break_det, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        set_ready(1'b1);
        idle_bits(1);

        // Basic frame with push latency check
        fork
            send_frame(8'hA5, 3'd0, 1'b0, 1'b1, 1'b1);
            watch_push();
        join
        idle_bits(2);

        // Even parity, wrong then right parity bit
        send_frame(8'h03, 3'd1, 1'b1, 1'b1, 1'b1);
        idle_bits(2);
        send_frame(8'h03, 3'd1, 1'b0, 1'b1, 1'b1);
        idle_bits(2);

        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            send_frame(d, modes[i], 1'(i % 2), 1'b1, 1'b1);
            idle_bits(2);
        end

        // All-zero data with framing error but parity bit 1: a normal word, not a break
        send_frame(8'h00, 3'd1, 1'b1, 1'b0, 1'b1);
        idle_bits(2);
        wait_drain();

        // Start-bit glitch
        rxd = 1'b0;
        repeat (4 * TICK_DIV) @(negedge clk);
        rxd = 1'b1;
        check("glitch_busy_start", busy, 1'b1);
        repeat (OSR * TICK_DIV) @(negedge clk);
        check("glitch_busy_end", busy, 1'b0);
        send_frame(8'h5A, 3'd0, 1'b0, 1'b1, 1'b1);
        idle_bits(2);

        // Framing error then break
        send_frame(8'h55, 3'd0, 1'b0, 1'b0, 1'b1);
        rxd = 1'b0;
        repeat (20 * BIT_CLKS) @(negedge clk);
        check("break_busy_held", busy, 1'b1);
        check("break_state", dbg_state, 3'd5);
        check("break_pulses", brk_cnt, 1);
        idle_bits(1);
        check("break_released", busy, 1'b0);
        check("break_pulses_after", brk_cnt, 1);
        check("break_no_push", 32'(exp_q.size()), 32'd0);

        // Two stop bits
        stop2 = 1'b1;
        send_frame(8'h96, 3'd1, 1'b0, 1'b1, 1'b1);
        idle_bits(2);
        send_frame(8'h69, 3'd0, 1'b0, 1'b0, 1'b1);
        idle_bits(2);
        stop2 = 1'b0;
        wait_drain();

        // Fill the FIFO, then overflow it
        set_ready(1'b0);
        for (int i = 1; i <= FIFO_DEPTH; i++) begin
            send_frame(8'(i), 3'd0, 1'b0, 1'b1, 1'b1);
            idle_bits(1);
        end
        check("full_no_overrun", overrun, 1'b0);
        check("full_valid", rx_valid, 1'b1);
        check("full_head", rx_data, 8'h01);
        send_frame(8'h05, 3'd0, 1'b0, 1'b1, 1'b0);
        idle_bits(1);
        check("overrun_set", overrun, 1'b1);
        set_ready(1'b1);
        wait_drain();
        repeat (2) @(negedge clk);
        check("drained_valid", rx_valid, 1'b0);
        check("overrun_sticky", overrun, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("overrun_cleared", overrun, 1'b0);

        // Receiver disabled mid data bit 3
        rxd = 1'b0;
        repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        check("en_state_data", dbg_state, 3'd2);
        rx_en = 1'b0;
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        check("en_off_idle", busy, 1'b0);
        idle_bits(2);
        rx_en = 1'b1;
        idle_bits(1);
        send_frame(8'h3C, 3'd0, 1'b0, 1'b1, 1'b1);
        idle_bits(2);
        wait_drain();

        // Reset mid-frame with a word held in the FIFO
        set_ready(1'b0);
        send_frame(8'h77, 3'd0, 1'b0, 1'b1, 1'b0);
        idle_bits(1);
        check("pre_rst_valid", rx_valid, 1'b1);
        check("pre_rst_data", rx_data, 8'h77);
        rxd = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        check("mid_rst_valid", rx_valid, 1'b0);
        check("mid_rst_data", rx_data, 8'h00);
        check("mid_rst_perr", rx_perr, 1'b0);
        check("mid_rst_ferr", rx_ferr, 1'b0);
        check("mid_rst_overrun", overrun, 1'b0);
        check("mid_rst_break", break_det, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        set_ready(1'b1);
        idle_bits(1);
        send_frame(8'hC3, 3'd0, 1'b0, 1'b1, 1'b1);
        idle_bits(2);
        wait_drain();

        // Final report
        check("total_break_pulses", brk_cnt, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
